// File: rtl/pwm_fault_sequencer.sv
// Supervisor over N_CH short-circuit protectors: gates PWM and runs bounded auto-recovery.
// Optional macro PWM_FAULT_SEQ_SYNC_EN adds 2-FF synchronizers on Start, Clear and ChOk.
module pwm_fault_sequencer #(
  parameter int N_CH       = 4,
  parameter int RETRY_MAX  = 3,
  parameter int COOL_CYC   = 50_000_000,
  parameter int RST_PULSE  = 4,
  parameter int STABLE_CYC = 25_000_000
) (
  input  logic            CLK_50M,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Clear,
  input  logic [N_CH-1:0] ChOk,
  output logic            ResetD,
  output logic            PWM_Gate,
  output logic            Fault,
  output logic [N_CH-1:0] FaultMask,
  output logic [2:0]      RetryCnt,
  output logic [2:0]      State
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam int SW = $clog2(STABLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_COOL  = 3'd2,
    S_RESET = 3'd3,
    S_CHECK = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  logic            start;
  logic            clear;
  logic [N_CH-1:0] chOk;
  logic            allOk;

`ifdef PWM_FAULT_SEQ_SYNC_EN
  logic [1:0]      startSync_q;
  logic [1:0]      clearSync_q;
  logic [N_CH-1:0] chOkMeta_q;
  logic [N_CH-1:0] chOkSync_q;

  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      startSync_q <= '0;
      clearSync_q <= '0;
      chOkMeta_q  <= '0;
      chOkSync_q  <= '0;
    end else begin
      startSync_q <= {startSync_q[0], Start};
      clearSync_q <= {clearSync_q[0], Clear};
      chOkMeta_q  <= ChOk;
      chOkSync_q  <= chOkMeta_q;
    end
  end

  assign start = startSync_q[1];
  assign clear = clearSync_q[1];
  assign chOk  = chOkSync_q;
`else
  assign start = Start;
  assign clear = Clear;
  assign chOk  = ChOk;
`endif

  assign allOk = &chOk;

  state_t          state_q;
  logic            resetD_q;
  logic            gate_q;
  logic            fault_q;
  logic [N_CH-1:0] faultMask_q;
  logic [2:0]      retryCnt_q;
  logic [25:0]     coolCnt_q;
  logic [PW-1:0]   pulseCnt_q;
  logic [SW-1:0]   stableCnt_q;
  logic            abortPend_q;

  // Gate rises one edge after entering RUN but drops on the same edge that leaves it.
  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      resetD_q    <= 1'b0;
      gate_q      <= 1'b0;
      fault_q     <= 1'b0;
      faultMask_q <= '0;
      retryCnt_q  <= '0;
      coolCnt_q   <= '0;
      pulseCnt_q  <= '0;
      stableCnt_q <= '0;
      abortPend_q <= 1'b0;
    end else begin
      resetD_q    <= 1'b0;
      gate_q      <= 1'b0;
      fault_q     <= 1'b0;
      stableCnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start && allOk) begin
            state_q <= S_RUN;
            if (retryCnt_q == 3'd0) faultMask_q <= '0;
          end
        end
        S_RUN: begin
          if (!allOk) begin
            state_q     <= S_COOL;
            coolCnt_q   <= '0;
            faultMask_q <= faultMask_q | ~chOk;
          end else if (!start) begin
            state_q <= S_IDLE;
          end else begin
            gate_q <= 1'b1;
            if (stableCnt_q != SW'(STABLE_CYC)) begin
              stableCnt_q <= stableCnt_q + 1'b1;
              if (stableCnt_q == SW'(STABLE_CYC - 1)) retryCnt_q <= '0;
            end else begin
              stableCnt_q <= stableCnt_q;
            end
          end
        end
        S_COOL: begin
          if (!start) begin
            state_q <= S_IDLE;
          end else if (coolCnt_q == 26'(COOL_CYC - 1)) begin
            if (retryCnt_q < 3'(RETRY_MAX)) begin
              state_q     <= S_RESET;
              retryCnt_q  <= retryCnt_q + 3'd1;
              resetD_q    <= 1'b1;
              pulseCnt_q  <= '0;
              abortPend_q <= 1'b0;
            end else begin
              state_q <= S_LOCK;
              fault_q <= 1'b1;
            end
          end else begin
            coolCnt_q <= coolCnt_q + 26'd1;
          end
        end
        S_RESET: begin
          // A Start drop anywhere in the pulse is remembered so the pulse still completes.
          if (!start) abortPend_q <= 1'b1;
          if (pulseCnt_q == PW'(RST_PULSE - 1)) begin
            state_q <= (abortPend_q || !start) ? S_IDLE : S_CHECK;
          end else begin
            pulseCnt_q <= pulseCnt_q + 1'b1;
            resetD_q   <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!allOk) begin
            state_q     <= S_COOL;
            coolCnt_q   <= '0;
            faultMask_q <= faultMask_q | ~chOk;
          end else if (!start) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_LOCK: begin
          if (clear) begin
            state_q     <= S_IDLE;
            faultMask_q <= '0;
            retryCnt_q  <= '0;
          end else begin
            fault_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ResetD    = resetD_q;
  assign PWM_Gate  = gate_q;
  assign Fault     = fault_q;
  assign FaultMask = faultMask_q;
  assign RetryCnt  = retryCnt_q;
  assign State     = state_q;

endmodule

// File: tb/tb_pwm_fault_sequencer.sv
// Directed bench for pwm_fault_sequencer with short timing parameters (sync disabled).
module tb_pwm_fault_sequencer;

  logic       CLK_50M = 1'b0;
  logic       Rst_n   = 1'b0;
  logic       Start   = 1'b0;
  logic       Clear   = 1'b0;
  logic [3:0] ChOk    = 4'hF;
  logic       ResetD;
  logic       PWM_Gate;
  logic       Fault;
  logic [3:0] FaultMask;
  logic [2:0] RetryCnt;
  logic [2:0] State;

  int testsRun  = 0;
  int testsFail = 0;

  pwm_fault_sequencer #(
    .N_CH(4), .RETRY_MAX(2), .COOL_CYC(10), .RST_PULSE(4), .STABLE_CYC(20)
  ) dut (
    .CLK_50M(CLK_50M), .Rst_n(Rst_n), .Start(Start), .Clear(Clear), .ChOk(ChOk),
    .ResetD(ResetD), .PWM_Gate(PWM_Gate), .Fault(Fault), .FaultMask(FaultMask),
    .RetryCnt(RetryCnt), .State(State)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct {
    logic       rstn, start, clear;
    logic [3:0] chOk;
    logic [2:0] state;
    logic       gate, resetD, fault;
    logic [3:0] mask;
    logic [2:0] retry;
  } vec_t;

  vec_t vecs[11];

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_50M);
    #1;
  endtask

  task automatic applyStimulus(input logic rstn, input logic start, input logic clear,
                               input logic [3:0] chOk);
    Rst_n = rstn;
    Start = start;
    Clear = clear;
    ChOk  = chOk;
    tick(1);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input int st, input int g, input int rd,
                          input int f, input int m, input int r);
    checkOutput({name, ".State"}, int'(State), st);
    checkOutput({name, ".Gate"}, int'(PWM_Gate), g);
    checkOutput({name, ".ResetD"}, int'(ResetD), rd);
    checkOutput({name, ".Fault"}, int'(Fault), f);
    checkOutput({name, ".Mask"}, int'(FaultMask), m);
    checkOutput({name, ".Retry"}, int'(RetryCnt), r);
  endtask

  task automatic startRun();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF);
    tick(1);
  endtask

  initial begin
    int n;
    int hi;
    int pulses;
    logic prevRd;

    //            rstn start clr chOk   state gate rd flt mask retry
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'hB, 3'd2, 1'b0, 1'b0, 1'b0, 4'h4, 3'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'hB, 3'd2, 1'b0, 1'b0, 1'b0, 4'h4, 3'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 4'h4, 3'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'hE, 3'd2, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'hF, 3'd2, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0};

    #1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].start, vecs[i].clear, vecs[i].chOk);
      checkAll($sformatf("vec%0d", i), vecs[i].state, vecs[i].gate, vecs[i].resetD,
               vecs[i].fault, vecs[i].mask, vecs[i].retry);
    end

    // Single trip: cool-down length, exact ResetD width, recovery to RUN.
    startRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hB);
    checkAll("trip", 2, 0, 0, 0, 4, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hB);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hB);
    ChOk = 4'hF;
    tick(7);
    checkOutput("cool9.State", int'(State), 2);
    checkOutput("cool9.ResetD", int'(ResetD), 0);
    tick(1);
    checkAll("pulseStart", 3, 0, 1, 0, 4, 1);
    hi = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ResetD) hi++;
      else break;
    end
    checkOutput("pulseWidth", hi, 4);
    checkOutput("afterPulse.State", int'(State), 4);
    tick(1);
    checkAll("recoverRun", 1, 0, 0, 0, 4, 1);
    tick(1);
    checkOutput("recoverGate", int'(PWM_Gate), 1);

    // Persistent fault: two retries then lockout.
    startRun();
    ChOk = 4'h7;
    n = 0;
    pulses = 0;
    prevRd = 1'b0;
    while (!Fault && n < 200) begin
      tick(1);
      n++;
      if (ResetD && !prevRd) pulses++;
      prevRd = ResetD;
    end
    checkOutput("lockCycles", n, 41);
    checkOutput("lockPulses", pulses, 2);
    checkAll("lock", 5, 0, 0, 1, 8, 2);
    tick(3);
    checkOutput("lockHold.State", int'(State), 5);

    // Clear only acts in LOCK; Start is ignored there.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
    checkAll("lockNoStart", 5, 0, 0, 1, 8, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
    checkAll("cleared", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
    checkAll("clearInRun", 1, 1, 0, 0, 0, 0);

    // Retry decay after STABLE_CYC continuous RUN cycles.
    startRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hB);
    ChOk = 4'hF;
    n = 0;
    while (State != 3'd1 && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput("decayBefore", int'(RetryCnt), 1);
    tick(19);
    checkOutput("decay19", int'(RetryCnt), 1);
    tick(1);
    checkOutput("decay20", int'(RetryCnt), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hE);
    ChOk = 4'hF;
    n = 0;
    while (State != 3'd3 && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput("retripRetry", int'(RetryCnt), 1);
    checkOutput("retripMask", int'(FaultMask), 5);

    // Reset in the middle of the ResetD pulse truncates it.
    startRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hB);
    ChOk = 4'hF;
    n = 0;
    while (!ResetD && n < 100) begin
      tick(1);
      n++;
    end
    tick(1);
    checkOutput("midPulse.ResetD", int'(ResetD), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
    checkAll("midPulseReset", 0, 0, 0, 0, 0, 0);
    Rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
